ultrasonic_ranger_array: RTL



---
 rtl/ultrasonic_ranger_array.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ultrasonic_ranger_array: round-robin HC-SR04 ranging controller for N_CH sensors.
// Optional RANGER_AVG_EN adds a 4-sample moving average per channel.  Rev 1.0
// ----------------------------------------------------------------------------
module ultrasonic_ranger_array #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int N_CH       = 2,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int HOLDOFF_US = 60000,
   parameter int DEPTH_W    = 16,
   localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                      CLK100MHZ,
   input  logic                      CPU_RESETN,
   input  logic                      enable,
   input  logic [N_CH-1:0]           SENSOR_ECHO,
   output logic [N_CH-1:0]           SENSOR_TRIG,
   output logic [N_CH*DEPTH_W-1:0]   depth,
   output logic [N_CH-1:0]           depth_valid,
   output logic [N_CH-1:0]           timeout,
   output logic [CH_W-1:0]           active_ch
);

   localparam int DIV   = CLK_HZ / 1_000_000;
   localparam int PS_W  = $clog2(DIV);
   localparam int T_MAX = (TIMEOUT_US > HOLDOFF_US)
                        ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                        : ((HOLDOFF_US > TRIG_US) ? HOLDOFF_US : TRIG_US);
   localparam int TMR_W = $clog2(T_MAX + 1);

   localparam logic [TMR_W-1:0]   TRIG_END = TMR_W'(TRIG_US - 1);
   localparam logic [TMR_W-1:0]   TO_END   = TMR_W'(TIMEOUT_US - 1);
   localparam logic [TMR_W-1:0]   TO_VAL   = TMR_W'(TIMEOUT_US);
   localparam logic [TMR_W-1:0]   HOLD_END = TMR_W'(HOLDOFF_US - 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
   localparam logic [N_CH-1:0]    CH_ONE    = N_CH'(1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TRIG = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_MEAS = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic [N_CH-1:0]    echo_meta, echo_sync;
   logic [PS_W-1:0]    presc;
   logic               us_tick;
   logic [2:0]         state;
   logic [TMR_W-1:0]   timer, w_next;
   logic               echo_cur, echo_last, meas_done;
   logic [CH_W-1:0]    next_ch;
   logic [31:0]        prod, quot;
   logic [DEPTH_W-1:0] raw_depth;
   logic [DEPTH_W-1:0] depth_q [N_CH];

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         echo_meta <= '0;
         echo_sync <= '0;
         presc     <= '0;
      end else begin
         echo_meta <= SENSOR_ECHO;
         echo_sync <= echo_meta;
         presc     <= us_tick ? '0 : presc + 1'b1;
      end
   end

   assign us_tick   = (presc == PS_W'(DIV - 1));
   assign echo_cur  = echo_sync[active_ch];
   assign w_next    = timer + 1'b1;
   assign next_ch   = (active_ch == CH_W'(N_CH - 1)) ? '0 : active_ch + 1'b1;
   assign meas_done = us_tick && (state == S_MEAS) && !echo_cur;

   // w_next is the elapsed tick count from the sampled rise to the sampled fall.
   assign prod      = 32'(w_next) * 32'd343;
   assign quot      = prod / 32'd2000;
   assign raw_depth = (quot > 32'(DEPTH_MAX)) ? DEPTH_MAX : quot[DEPTH_W-1:0];

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state       <= S_IDLE;
         timer       <= '0;
         echo_last   <= 1'b0;
         active_ch   <= '0;
         SENSOR_TRIG <= '0;
         timeout     <= '0;
      end else if (us_tick) begin
         // Tracking the previous sample from TRIG onward means an echo already high on WAIT entry is not a rise.
         echo_last <= echo_cur;
         case (state)
            S_IDLE: if (enable) begin
               state       <= S_TRIG;
               timer       <= '0;
               SENSOR_TRIG <= CH_ONE << active_ch;
            end
            S_TRIG: if (timer == TRIG_END) begin
               state       <= S_WAIT;
               timer       <= '0;
               SENSOR_TRIG <= '0;
            end else begin
               timer <= w_next;
            end
            S_WAIT: if (echo_cur && !echo_last) begin
               state <= S_MEAS;
               timer <= '0;
            end else if (timer == TO_END) begin
               timeout[active_ch] <= 1'b1;
               state              <= S_HOLD;
               timer              <= '0;
            end else begin
               timer <= w_next;
            end
            S_MEAS: if (!echo_cur) begin
               timeout[active_ch] <= 1'b0;
               state              <= S_HOLD;
               timer              <= '0;
            end else if (w_next == TO_VAL) begin
               timeout[active_ch] <= 1'b1;
               state              <= S_HOLD;
               timer              <= '0;
            end else begin
               timer <= w_next;
            end
            S_HOLD: if (timer == HOLD_END) begin
               active_ch <= next_ch;
               timer     <= '0;
               if (enable) begin
                  state       <= S_TRIG;
                  SENSOR_TRIG <= CH_ONE << next_ch;
               end else begin
                  state <= S_IDLE;
               end
            end else begin
               timer <= w_next;
            end
            default: begin
               state       <= S_IDLE;
               SENSOR_TRIG <= '0;
            end
         endcase
      end
   end

`ifdef RANGER_AVG_EN
   localparam int SUM_W = DEPTH_W + 2;

   logic               cap_vld;
   logic [DEPTH_W-1:0] cap_depth;
   logic [DEPTH_W-1:0] hist [N_CH][3];
   logic [N_CH-1:0]    primed;
   logic [SUM_W-1:0]   avg_sum;

   // The incoming sample plus the three stored ones form the 4-entry window.
   assign avg_sum = SUM_W'(cap_depth) + SUM_W'(hist[active_ch][0])
                  + SUM_W'(hist[active_ch][1]) + SUM_W'(hist[active_ch][2]);

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         cap_vld     <= 1'b0;
         cap_depth   <= '0;
         primed      <= '0;
         depth_valid <= '0;
         for (int k = 0; k < N_CH; k++) begin
            depth_q[k] <= '0;
            for (int j = 0; j < 3; j++) hist[k][j] <= '0;
         end
      end else begin
         cap_vld     <= meas_done;
         depth_valid <= '0;
         if (meas_done) cap_depth <= raw_depth;
         if (cap_vld) begin
            depth_valid[active_ch] <= 1'b1;
            primed[active_ch]      <= 1'b1;
            hist[active_ch][0]     <= cap_depth;
            if (primed[active_ch]) begin
               hist[active_ch][1] <= hist[active_ch][0];
               hist[active_ch][2] <= hist[active_ch][1];
               depth_q[active_ch] <= avg_sum[SUM_W-1:2];
            end else begin
               hist[active_ch][1] <= cap_depth;
               hist[active_ch][2] <= cap_depth;
               depth_q[active_ch] <= cap_depth;
            end
         end
      end
   end
`else
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         depth_valid <= '0;
         for (int k = 0; k < N_CH; k++) depth_q[k] <= '0;
      end else begin
         depth_valid <= '0;
         if (meas_done) begin
            depth_valid[active_ch] <= 1'b1;
            depth_q[active_ch]     <= raw_depth;
         end
      end
   end
`endif

   generate
      for (genvar k = 0; k < N_CH; k++) begin : g_pack
         assign depth[k*DEPTH_W +: DEPTH_W] = depth_q[k];
      end
   endgenerate

endmodule
`default_nettype wire
